// File: rtl/uart_tx.sv
// uart_tx: LSB-first serial transmitter with one start bit, UART_DATA_SIZE data
// bits and STOP_BITS stop bits. A byte is accepted only on the rising edge of
// i_tx_valid while idle, so a request held for many cycles sends one frame.
// Every output is registered and is computed from the next-state values, so
// o_tx reflects the new frame position on the same edge the state changes.
module uart_tx #(
    parameter int UART_DATA_SIZE = 8,
    parameter int BAUD_DIVISOR   = 5208,
    parameter int STOP_BITS      = 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [UART_DATA_SIZE-1:0] i_tx_data,
    input  logic                      i_tx_valid,
    output logic                      o_tx_ready,
    output logic                      o_tx,
    output logic                      o_tx_done
);

    localparam int CNT_W = $clog2(BAUD_DIVISOR);
    localparam int IDX_W = 3;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIVISOR - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(UART_DATA_SIZE - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } state_t;

    state_t                    state_q, state_d;
    logic                      valid_q, valid_d;
    logic [CNT_W-1:0]          baud_q, baud_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_SIZE-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      ready_q, ready_d;
    logic                      done_q, done_d;

    logic                      accept_s;
    logic                      baud_end_s;

    // State, datapath and output registers; reset parks the line high and
    // pre-sets valid_q so a request already high at release is ignored.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b1;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update: bit timing, bit index and shifting.
    always_comb begin
        state_d    = state_q;
        valid_d    = i_tx_valid;
        baud_d     = baud_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        accept_s   = (state_q == ST_IDLE) && i_tx_valid && !valid_q;
        baud_end_s = (baud_q == BAUD_LAST);

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_START;
                    baud_d  = '0;
                    idx_d   = '0;
                    shift_d = i_tx_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    idx_d   = '0;
                end else begin
                    baud_d  = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[UART_DATA_SIZE-1:1]};
                    if (idx_q == DATA_LAST) begin
                        state_d = ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d  = baud_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // idx_q counts stop bits here, so two stop bits need no extra counter.
                if (baud_end_s) begin
                    baud_d = '0;
                    if (idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                idx_d   = '0;
                shift_d = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            ST_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                done_d  = (state_q == ST_STOP);
            end
            ST_START: begin
                tx_d = 1'b0;
            end
            ST_DATA: begin
                tx_d = shift_d[0];
            end
            ST_STOP: begin
                tx_d = 1'b1;
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign o_tx       = tx_q;
    assign o_tx_ready = ready_q;
    assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: BAUD_DIVISOR = 4, 8 data bits. Instance 1 uses one
// stop bit, instance 2 uses two. Expected line values come from a frame model
// indexed by cycle since the accept edge.
module tb_uart_tx;

    localparam int B = 4;
    localparam int N = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] data1, data2;
    logic       valid1, valid2;
    logic       ready1, tx1, done1;
    logic       ready2, tx2, done2;

    int checks   = 0;
    int failures = 0;

    uart_tx #(.UART_DATA_SIZE(N), .BAUD_DIVISOR(B), .STOP_BITS(1)) dut1 (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_tx_data  (data1),
        .i_tx_valid (valid1),
        .o_tx_ready (ready1),
        .o_tx       (tx1),
        .o_tx_done  (done1)
    );

    uart_tx #(.UART_DATA_SIZE(N), .BAUD_DIVISOR(B), .STOP_BITS(2)) dut2 (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_tx_data  (data2),
        .i_tx_valid (valid2),
        .o_tx_ready (ready2),
        .o_tx       (tx2),
        .o_tx_done  (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial line level k cycles after the accept edge: start bit, data LSB first, then high.
    function automatic logic exp_line(input logic [7:0] d, input int k);
        int bi;
        bi = k / B;
        if (bi == 0) return 1'b0;
        if (bi <= N) return d[bi-1];
        return 1'b1;
    endfunction

    // Send one byte on the chosen instance and compare tx/ready/done every cycle.
    task automatic drive_frame(input int inst, input logic [7:0] d, input int hold,
                               input int change_at, input bit rand_data, input string name);
        int   sb;
        int   fl;
        int   last;
        int   w;
        logic o_tx, o_rdy, o_done, e_tx, e_rdy, e_done;
        sb   = (inst == 2) ? 2 : 1;
        fl   = (1 + N + sb) * B;
        last = (hold + 1 > fl + 1) ? hold + 1 : fl + 1;
        w    = 0;
        @(negedge clk);
        while (((inst == 2) ? ready2 : ready1) !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (((inst == 2) ? ready2 : ready1) !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_wait: ready=%b required 1", name,
                     (inst == 2) ? ready2 : ready1);
            return;
        end
        if (inst == 2) begin data2 = d; valid2 = 1'b1; end
        else           begin data1 = d; valid1 = 1'b1; end
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            o_tx   = (inst == 2) ? tx2 : tx1;
            o_rdy  = (inst == 2) ? ready2 : ready1;
            o_done = (inst == 2) ? done2 : done1;
            e_tx   = exp_line(d, k);
            e_rdy  = (k >= fl);
            e_done = (k == fl);
            checks++;
            if ({o_tx, o_rdy, o_done} !== {e_tx, e_rdy, e_done}) begin
                failures++;
                $display("FAIL %s cycle %0d data %02h: tx/ready/done=%b%b%b required %b%b%b",
                         name, k, d, o_tx, o_rdy, o_done, e_tx, e_rdy, e_done);
            end
            if (k + 1 >= hold) begin
                if (inst == 2) valid2 = 1'b0; else valid1 = 1'b0;
            end
            if (k == change_at) begin
                if (inst == 2) data2 = 8'hFF; else data1 = 8'hFF;
            end else if (rand_data) begin
                if (inst == 2) data2 = 8'($urandom); else data1 = 8'($urandom);
            end
        end
        valid1 = 1'b0;
        valid2 = 1'b0;
    endtask

    // Reset values, then a valid already high at release must not start a frame.
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx1, ready1, done1, tx2, ready2, done2} !== 6'b110110) begin
            failures++;
            $display("FAIL reset_values: tx/ready/done=%b%b%b %b%b%b required 110 110",
                     tx1, ready1, done1, tx2, ready2, done2);
        end
        valid1 = 1'b1;
        data1  = 8'($urandom);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({tx1, ready1} !== 2'b11) begin
                failures++;
                $display("FAIL reset_held_valid cycle %0d: tx/ready=%b%b required 11", k, tx1, ready1);
            end
        end
        valid1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        drive_frame(1, 8'hA5, 5, -1, 1'b0, "single_a5");
    endtask

    task automatic test_held_valid();
        drive_frame(1, 8'h3C, 100, -1, 1'b0, "held_3c");
    endtask

    task automatic test_data_change();
        drive_frame(1, 8'h55, 3, 10, 1'b0, "change_55");
    endtask

    task automatic test_two_stop();
        drive_frame(2, 8'h00, 2, -1, 1'b0, "two_stop_00");
        drive_frame(2, 8'($urandom), 7, -1, 1'b1, "two_stop_rand");
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 12; i++) begin
            drive_frame(int'($urandom_range(1, 2)), 8'($urandom),
                        int'($urandom_range(1, 60)), -1, 1'b1, "random");
        end
    endtask

    // Three single-cycle requests gated by ready; decode the captured line.
    task automatic test_back_to_back();
        logic       line_q[$];
        logic [7:0] got[$];
        logic [7:0] exp_b[3];
        logic [7:0] b;
        int         i;
        exp_b[0] = 8'h01;
        exp_b[1] = 8'h02;
        exp_b[2] = 8'h03;
        fork
            begin
                for (int c = 0; c < 170; c++) begin
                    @(negedge clk);
                    line_q.push_back(tx1);
                end
            end
            begin
                for (int n = 0; n < 3; n++) begin
                    int w;
                    w = 0;
                    @(negedge clk);
                    while (ready1 !== 1'b1 && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    checks++;
                    if (ready1 !== 1'b1) begin
                        failures++;
                        $display("FAIL b2b_ready_wait byte %0d: ready=%b required 1", n, ready1);
                    end
                    data1  = exp_b[n];
                    valid1 = 1'b1;
                    @(negedge clk);
                    valid1 = 1'b0;
                    data1  = 8'($urandom);
                end
            end
        join
        i = 0;
        while (i + 38 < line_q.size()) begin
            if (line_q[i] == 1'b0 && (i == 0 || line_q[i-1] == 1'b1)) begin
                for (int j = 0; j < 8; j++) b[j] = line_q[i + 4 * (j + 1) + 2];
                if (line_q[i+2] == 1'b0 && line_q[i+38] == 1'b1) got.push_back(b);
                i = i + 40;
            end else begin
                i++;
            end
        end
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL b2b_frame_count: decoded %0d frames required 3", got.size());
        end
        for (int n = 0; n < 3; n++) begin
            if (n < got.size()) begin
                checks++;
                if (got[n] !== exp_b[n]) begin
                    failures++;
                    $display("FAIL b2b_byte %0d: decoded %02h required %02h", n, got[n], exp_b[n]);
                end
            end
        end
    endtask

    // Reset during data bit 3 with valid held; line must rise without a clock edge.
    task automatic test_reset_mid_frame();
        @(negedge clk);
        data1  = 8'hF0;
        valid1 = 1'b1;
        for (int k = 0; k <= 17; k++) @(negedge clk);
        checks++;
        if (tx1 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_pre: tx=%b required 0", tx1);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx1, ready1, done1} !== 3'b110) begin
            failures++;
            $display("FAIL mid_reset_async: tx/ready/done=%b%b%b required 110", tx1, ready1, done1);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if ({tx1, ready1} !== 2'b11) begin
                failures++;
                $display("FAIL mid_reset_no_restart cycle %0d: tx/ready=%b%b required 11", k, tx1, ready1);
            end
        end
        valid1 = 1'b0;
        @(negedge clk);
        valid1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx1, ready1} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset_new_accept: tx/ready=%b%b required 00", tx1, ready1);
        end
        valid1 = 1'b0;
        repeat (45) @(negedge clk);
        checks++;
        if ({tx1, ready1} !== 2'b11) begin
            failures++;
            $display("FAIL mid_reset_frame_end: tx/ready=%b%b required 11", tx1, ready1);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        valid1 = 1'b0;
        valid2 = 1'b0;
        data1  = 8'h00;
        data2  = 8'h00;
        test_reset();
        test_single_byte();
        test_held_valid();
        test_data_change();
        test_back_to_back();
        test_two_stop();
        test_reset_mid_frame();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter UART_DATA_SIZE, default 8, data bits per frame; legal range 5 to 8.
REQ-002 Parameter BAUD_DIVISOR, default 5208, i_clock cycles per serial bit (50 MHz / 9600 baud); legal minimum 2.
REQ-003 Parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-004 Port i_clock  input  1  system clock; every register SHALL update on its rising edge.
REQ-005 Port i_reset_n  input  1  reset; asynchronous, active-low.
REQ-006 Port i_tx_data  input  UART_DATA_SIZE  byte to transmit; sampled only on the accept cycle.
REQ-007 Port i_tx_valid  input  1  request from the logger stage; level-held for several cycles per byte.
REQ-008 Port o_tx_ready  output  1  high only while the block is IDLE and able to accept.
REQ-009 Port o_tx  output  1  serial line; idle high; LSB-first 8N1-style frame.
REQ-010 Port o_tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, START, DATA and STOP.
REQ-012 The block SHALL register i_tx_valid into valid_q each cycle and SHALL detect an accept as (state == IDLE) AND i_tx_valid AND NOT valid_q.
- Consequence: a valid held high for N cycles yields exactly one frame.
REQ-013 On accept, the block SHALL latch i_tx_data into a shift register, clear the baud counter and the bit index, and enter START on the next edge.
REQ-014 A valid that is already high on leaving IDLE SHALL NOT be accepted again; the block SHALL accept a new byte only after valid returns low and rises again.
REQ-015 All outputs SHALL be registered; o_tx SHALL go low on the first cycle after the accept edge.
REQ-016 The baud counter SHALL count 0 to BAUD_DIVISOR-1 in START, DATA and STOP; at BAUD_DIVISOR-1 it SHALL wrap to 0 and the bit advances.
REQ-017 In START, o_tx SHALL be 0 for BAUD_DIVISOR cycles, then the FSM SHALL enter DATA.
REQ-018 In DATA, o_tx SHALL drive shift[0] for BAUD_DIVISOR cycles per bit, then the register SHALL shift right.
- The FSM SHALL leave DATA after bit index UART_DATA_SIZE-1 completes.
REQ-019 In STOP, o_tx SHALL be 1 for STOP_BITS*BAUD_DIVISOR cycles.
- Then the FSM SHALL return to IDLE and o_done SHALL pulse high for exactly that one transition cycle.
REQ-020 o_tx_ready SHALL be 0 from the cycle after accept until the cycle IDLE is re-entered, and 1 in IDLE.
REQ-021 Frame length SHALL be (1 + UART_DATA_SIZE + STOP_BITS) * BAUD_DIVISOR cycles exactly; no idle gap SHALL be inserted beyond STOP.
REQ-022 Changes on i_tx_data or i_tx_valid during START/DATA/STOP SHALL NOT affect the frame in flight.
REQ-023 If accept conditions and STOP completion coincide, the block SHALL complete STOP and enter IDLE; acceptance SHALL be evaluated only from IDLE, on a later edge.
REQ-024 Unreachable state encodings SHALL return to IDLE with o_tx = 1 on the next edge.

Reset
REQ-025 While i_reset_n = 0, the block SHALL force:
- state IDLE;
- o_tx = 1, o_tx_ready = 1, o_tx_done = 0;
- valid_q = 1, so a valid already high at release is not accepted;
- baud counter, bit index and shift register = 0.
REQ-026 Reset assertion mid-frame SHALL abort the frame immediately (asynchronously), with o_tx returning high without waiting for a clock edge.

Verification (BAUD_DIVISOR = 4, UART_DATA_SIZE = 8, STOP_BITS = 1 unless stated)
REQ-027 Scenario: single byte.
- Stimulus: i_tx_data = 0xA5, valid high for 5 cycles.
- Response: o_tx sequence in 4-cycle bits is 0,1,0,1,0,0,1,0,1,1; o_tx_ready low for 40 cycles; one o_tx_done pulse.
REQ-028 Scenario: held valid.
- Stimulus: valid held high for 100 cycles with 0x3C.
- Response: exactly one frame; o_tx high from cycle 41 onward.
REQ-029 Scenario: logger handshake.
- Stimulus: bytes 0x01, 0x02, 0x03 sent as a valid pulse each, then wait for o_tx_ready.
- Response: three back-to-back frames decoded as 0x01, 0x02, 0x03 with no duplicates.
REQ-030 Scenario: mid-frame data change.
- Stimulus: i_tx_data changes 0x55 -> 0xFF at cycle 10 of the frame.
- Response: 0x55 decoded.
REQ-031 Scenario: reset mid-frame.
- Stimulus: i_reset_n low during DATA bit 3, with valid high when reset is released.
- Response: o_tx = 1 immediately; o_tx_ready = 1; no frame starts until valid falls and rises again.
REQ-032 Scenario: STOP_BITS = 2, byte 0x00.
- Response: 44-cycle frame; o_tx low for 36 cycles, then high for 8.
